// File: rtl/vga_scan_driver_pkg.sv
// vga_scan_driver_pkg: default 640x480@60 raster timing shared by the scan driver and scene modules
package vga_scan_driver_pkg;
    localparam int X_DISPLAY  = 640;
    localparam int Y_DISPLAY  = 480;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int CNT_W      = 10;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(X_DISPLAY, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(Y_DISPLAY, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef logic [CNT_W-1:0] coord_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with wrap, visible-area and sync-region flags
module vga_axis_counter
    import vga_scan_driver_pkg::*;
#(
    parameter int ACTIVE = X_DISPLAY,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             in_active,
    output logic             in_sync
);
    localparam coord_t LAST    = coord_t'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
    localparam coord_t ACT_END = coord_t'(ACTIVE);
    localparam coord_t SYNC_LO = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_HI = coord_t'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (en) cnt <= wrap ? '0 : cnt + coord_t'(1);
    end

    always_comb begin
        wrap      = cnt == LAST;
        in_active = cnt < ACT_END;
        in_sync   = (cnt >= SYNC_LO) && (cnt < SYNC_HI);
    end
endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA raster scan, one-tick registered colour/sync output and frame/line strobes
module vga_scan_driver
    import vga_scan_driver_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = X_DISPLAY,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = Y_DISPLAY,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pixel,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        tick,
    output logic        active,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        line_start
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;

    always_ff @(posedge clk) begin
        if (reset) div <= '0;
        else div <= tick ? '0 : div + DW'(1);
    end

    assign tick = div == DW'(CLK_DIV - 1);

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(clk), .reset(reset), .en(tick),
        .cnt(x), .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(clk), .reset(reset), .en(tick & h_wrap),
        .cnt(y), .wrap(v_wrap), .in_active(v_act), .in_sync(v_sync)
    );

    always_comb begin
        line_start  = tick & h_wrap;
        frame_start = line_start & v_wrap;
        active      = h_act & v_act;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else if (tick) begin
            {vga_r, vga_g, vga_b} <= active ? pixel : 12'h000;
            hsync <= h_sync ^ ~SYNC_POL;
            vsync <= v_sync ^ ~SYNC_POL;
        end
    end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: three raster geometries checked every clk against an arithmetic position model
module tb_vga_scan_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic [11:0] pix [3];
    logic [9:0]  xo [3], yo [3];
    logic        tk [3], act [3], hs [3], vs [3], fs [3], ls [3];
    logic [3:0]  ro [3], go [3], bo [3];

    int cd  [3] = '{2, 1, 3};
    int ha  [3] = '{640, 20, 16};
    int hf  [3] = '{16, 2, 3};
    int hsw [3] = '{96, 3, 4};
    int hb  [3] = '{48, 2, 5};
    int va  [3] = '{480, 12, 8};
    int vf  [3] = '{10, 2, 1};
    int vsw [3] = '{2, 2, 3};
    int vb  [3] = '{33, 3, 2};
    bit sp  [3] = '{1'b0, 1'b0, 1'b1};

    vga_scan_driver dut0 (
        .clk(clk), .reset(rst[0]), .pixel(pix[0]), .x(xo[0]), .y(yo[0]), .tick(tk[0]), .active(act[0]),
        .vga_r(ro[0]), .vga_g(go[0]), .vga_b(bo[0]), .hsync(hs[0]), .vsync(vs[0]),
        .frame_start(fs[0]), .line_start(ls[0])
    );

    vga_scan_driver #(.CLK_DIV(1), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
                      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut1 (
        .clk(clk), .reset(rst[1]), .pixel(pix[1]), .x(xo[1]), .y(yo[1]), .tick(tk[1]), .active(act[1]),
        .vga_r(ro[1]), .vga_g(go[1]), .vga_b(bo[1]), .hsync(hs[1]), .vsync(vs[1]),
        .frame_start(fs[1]), .line_start(ls[1])
    );

    vga_scan_driver #(.CLK_DIV(3), .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
                      .V_ACTIVE(8), .V_FP(1), .V_SYNC(3), .V_BP(2), .SYNC_POL(1'b1)) dut2 (
        .clk(clk), .reset(rst[2]), .pixel(pix[2]), .x(xo[2]), .y(yo[2]), .tick(tk[2]), .active(act[2]),
        .vga_r(ro[2]), .vga_g(go[2]), .vga_b(bo[2]), .hsync(hs[2]), .vsync(vs[2]),
        .frame_start(fs[2]), .line_start(ls[2])
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] scene(input int h, input int v, input int s);
        logic [11:0] base;
        base = {4'(h), 4'(v), 4'h5};
        return base ^ 12'(s);
    endfunction

    int          k [3], salt [3];
    logic [11:0] er [3], pend [3];
    logic        ehs [3], evs [3], mt [3], ma [3], mh [3], mv [3];
    bit          dir_done [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            pix[i] = '0;
            k[i] = 0;
            salt[i] = int'($urandom);
            dir_done[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst[i]) begin
                    k[i] = 0;
                    er[i] = '0;
                    ehs[i] = !sp[i];
                    evs[i] = !sp[i];
                end else begin
                    if (mt[i]) begin
                        er[i] = ma[i] ? pend[i] : 12'h000;
                        ehs[i] = mh[i] ? sp[i] : !sp[i];
                        evs[i] = mv[i] ? sp[i] : !sp[i];
                    end
                    k[i]++;
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                int ht, vt, p, hc, vc;
                logic el, ef;
                string t;
                ht = hf[i] + ha[i] + hsw[i] + hb[i];
                vt = vf[i] + va[i] + vsw[i] + vb[i];
                p = k[i] / cd[i];
                hc = p % ht;
                vc = (p / ht) % vt;
                mt[i] = (k[i] % cd[i]) == cd[i] - 1;
                ma[i] = hc < ha[i] && vc < va[i];
                mh[i] = hc >= ha[i] + hf[i] && hc < ha[i] + hf[i] + hsw[i];
                mv[i] = vc >= va[i] + vf[i] && vc < va[i] + vf[i] + vsw[i];
                el = mt[i] && hc == ht - 1;
                ef = el && vc == vt - 1;
                t = $sformatf("d%0d k%0d", i, k[i]);
                check({t, " x"}, int'(xo[i]), hc);
                check({t, " y"}, int'(yo[i]), vc);
                check({t, " tick"}, int'(tk[i]), int'(mt[i]));
                check({t, " active"}, int'(act[i]), int'(ma[i]));
                check({t, " line_start"}, int'(ls[i]), int'(el));
                check({t, " frame_start"}, int'(fs[i]), int'(ef));
                check({t, " rgb"}, int'({ro[i], go[i], bo[i]}), int'(er[i]));
                check({t, " hsync"}, int'(hs[i]), int'(ehs[i]));
                check({t, " vsync"}, int'(vs[i]), int'(evs[i]));
                rst[i] = cyc < 2;
                if (!dir_done[i] && ((i == 0) ? (vc == 1 && hc == ha[i] + hf[i] + 10)
                                              : (vc == va[i] + vf[i] + vsw[i] - 1 && hc == ht - 3))) begin
                    dir_done[i] = 1'b1;
                    rst[i] = 1'b1;
                end
                if ($urandom_range(0, 4999) == 0) rst[i] = 1'b1;
                if (($urandom & 63) == 0) salt[i] = int'($urandom);
                pend[i] = scene(hc, vc, salt[i]);
                pix[i] = mt[i] ? pend[i] : 12'($urandom);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
